// File: rtl/div_if.sv
// Operand/request/result bundle between the ex stage (master) and the divider (slave).
interface div_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring divider with sequencing FSM; one quotient bit per cycle, MSB first.
// Result is {remainder, quotient}; outputs are registered.
module div_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input logic clk,
  input logic rst,
  div_if.slave bus
);
  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  dvd_neg_q, dvd_neg_d;
  logic                  quo_neg_q, quo_neg_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic                  op1_neg, op2_neg;
  logic [DATA_W-1:0]     op1_abs, op2_abs;
  // Upper half after the shift needs one extra bit: 2*rem+1 can exceed DATA_W bits.
  logic [DATA_W:0]       trial_up;
  logic [DATA_W-1:0]     trial_rem;
  logic                  trial_ge;
  logic [DATA_W-1:0]     quo_fix, rem_fix;

  assign op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign op1_abs = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign op2_abs = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

  assign trial_up  = work_q[2*DATA_W-1:DATA_W-1];
  assign trial_ge  = trial_up >= {1'b0, divisor_q};
  assign trial_rem = trial_ge ? DATA_W'(trial_up - {1'b0, divisor_q}) : trial_up[DATA_W-1:0];

  assign quo_fix = quo_neg_q ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
  assign rem_fix = dvd_neg_q ? -work_q[2*DATA_W-1:DATA_W] : work_q[2*DATA_W-1:DATA_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    dvd_neg_d = dvd_neg_q;
    quo_neg_d = quo_neg_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      StFree: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = StByZero;
          end else begin
            state_d   = StOn;
            cnt_d     = '0;
            work_d    = {{DATA_W{1'b0}}, op1_abs};
            divisor_d = op2_abs;
            dvd_neg_d = op1_neg;
            quo_neg_d = op1_neg ^ op2_neg;
          end
        end
      end
      StByZero: begin
        state_d  = StEnd;
        result_d = '0;
        ready_d  = 1'b1;
      end
      StOn: begin
        if (bus.annul_i) begin
          state_d  = StFree;
          result_d = '0;
          ready_d  = 1'b0;
          cnt_d    = '0;
        end else if (cnt_q != CntW'(DATA_W)) begin
          work_d = {trial_rem, work_q[DATA_W-2:0], trial_ge};
          cnt_d  = cnt_q + 1'b1;
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
          state_d  = StEnd;
        end
      end
      StEnd: begin
        if (!bus.start_i) begin
          state_d  = StFree;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = StFree;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      dvd_neg_q <= 1'b0;
      quo_neg_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      dvd_neg_q <= dvd_neg_d;
      quo_neg_q <= quo_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, results, hold/release, annul and async reset.
module tb_div_ctrl;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  div_if #(.DATA_W(32)) bus ();

  div_ctrl #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a request at a negedge and counts rising edges until ready_o; start stays high.
  task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output logic [63:0] res);
    @(negedge clk);
    bus.signed_div_i = sd;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    edges = 0;
    res   = '0;
    while (edges < 60) begin
      @(posedge clk);
      edges++;
      #1;
      if (bus.ready_o === 1'b1) begin
        res = bus.result_o;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #1;
    total_cnt++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0)
      $display("FAIL reset: ready=%b result=%h required ready=0 result=0",
               bus.ready_o, bus.result_o);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one division, checks latency, result, hold while start=1, and release.
  task automatic test_div(input string name, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input int exp_edges,
                          input logic [63:0] exp_res);
    int          edges;
    logic [63:0] res;
    run_div(sd, a, b, edges, res);
    total_cnt++;
    if (edges !== exp_edges)
      $display("FAIL %s latency: edges=%0d required %0d", name, edges, exp_edges);
    else pass_cnt++;
    total_cnt++;
    if (res !== exp_res)
      $display("FAIL %s result: got %h required %h", name, res, exp_res);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.ready_o !== 1'b1 || bus.result_o !== exp_res)
      $display("FAIL %s hold: ready=%b result=%h required ready=1 result=%h",
               name, bus.ready_o, bus.result_o, exp_res);
    else pass_cnt++;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0)
      $display("FAIL %s release: ready=%b result=%h required ready=0 result=0",
               name, bus.ready_o, bus.result_o);
    else pass_cnt++;
  endtask

  task automatic test_annul;
    int seen_ready;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen_ready = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready_o !== 1'b0) seen_ready++;
    end
    total_cnt++;
    if (seen_ready != 0)
      $display("FAIL annul: ready high on %0d cycles required 0", seen_ready);
    else pass_cnt++;
    test_div("after_annul", 1'b0, 32'd9, 32'd3, 34, {32'd0, 32'd3});
  endtask

  task automatic test_start_with_annul;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd50;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.ready_o !== 1'b0)
      $display("FAIL start_annul: ready=%b required 0", bus.ready_o);
    else pass_cnt++;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    int          edges;
    logic [63:0] res;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (21) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0)
      $display("FAIL reset_mid_op: ready=%b result=%h required 0/0",
               bus.ready_o, bus.result_o);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;
    test_div("after_reset", 1'b0, 32'd100, 32'd7, 34, {32'd2, 32'd14});

    // Reset while a result is presented must clear it without a clock edge.
    run_div(1'b0, 32'd100, 32'd7, edges, res);
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0)
      $display("FAIL reset_in_end: ready=%b result=%h required 0/0",
               bus.ready_o, bus.result_o);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_div("divu_100_7", 1'b0, 32'd100, 32'd7, 34, {32'h00000002, 32'h0000000E});
    test_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 34, {32'hFFFFFFFF, 32'hFFFFFFFD});
    test_div("div_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 34, {32'h00000001, 32'hFFFFFFFD});
    test_div("div_by_zero", 1'b0, 32'h12345678, 32'h0, 2, 64'h0);
    test_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'h1, 34, {32'h0, 32'hFFFFFFFF});
    test_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 34, {32'h0, 32'h80000000});
    test_div("divu_5_9", 1'b0, 32'd5, 32'd9, 34, {32'd5, 32'd0});
    test_div("divu_big_rem", 1'b0, 32'hFFFFFFFF, 32'h80000001, 34, {32'h7FFFFFFE, 32'h1});
    test_div("divu_near", 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 34, {32'hFFFFFFFE, 32'h0});
    test_annul();
    test_start_with_annul();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
